// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory access port: req/we/addr/wdata in, gnt/rvalid/rdata out.
// master = requester (CPU or I/O), slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// CPU / I/O arbiter in front of a single-port synchronous-read data memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on conflict (default: CPU priority).
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_arbiter_if.slave     cpu,
  mem_port_arbiter_if.slave     io,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_IO  = 1'b1;

  state_e                state_q;
  state_e                state_d;

  logic                  owner_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  any_req;
  logic                  pick_io;
  logic                  load;
  logic                  in_acc;
  logic                  in_resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  last_owner_q;

  // Remember who used the port last; starts at I/O so the CPU wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= OWN_IO;
    end else if (state_q == ACCESS) begin
      last_owner_q <= owner_q;
    end
  end
`endif

  // Pick the winner among pending requests.
  always_comb begin
    any_req = cpu.req | io.req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_io = io.req & (~cpu.req | (last_owner_q == OWN_CPU));
`else
    pick_io = io.req & ~cpu.req;
`endif
  end

  assign load = (state_q == IDLE) & any_req;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = any_req ? ACCESS : IDLE;
      ACCESS:  state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the winning request for the access cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load) begin
      owner_q <= pick_io;
      we_q    <= pick_io ? io.we    : cpu.we;
      addr_q  <= pick_io ? io.addr  : cpu.addr;
      wdata_q <= pick_io ? io.wdata : cpu.wdata;
    end
  end

  // Reset kills any access in flight in the same cycle.
  always_comb begin
    in_acc  = (state_q == ACCESS) & ~reset;
    in_resp = (state_q == RESP) & ~reset;
  end

  // Memory port and requester handshakes.
  always_comb begin
    mem_en     = in_acc;
    mem_we     = in_acc & we_q;
    mem_addr   = reset ? '0 : addr_q;
    mem_wdata  = reset ? '0 : wdata_q;
    cpu.gnt    = in_acc & (owner_q == OWN_CPU);
    io.gnt     = in_acc & (owner_q == OWN_IO);
    cpu.rvalid = in_resp & (owner_q == OWN_CPU);
    io.rvalid  = in_resp & (owner_q == OWN_IO);
    cpu.rdata  = cpu.rvalid ? mem_rdata : '0;
    io.rdata   = io.rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small sync-read memory model.
// Inputs driven and outputs checked on the falling edge.
module tb_mem_port_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          preload;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem [0:255];
  logic [1:0]    exp_g;
  int            n_acc;
  int            errors = 0;
  int            checks = 0;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) cpu_if ();
  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) io_if ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_if),
    .io        (io_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      mem[8'h20] <= 16'h1234;
      mem_rdata  <= 16'h0000;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [69:0] obs,
                     input logic [69:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    io_if.req = 1'b0; io_if.we = 1'b0; io_if.addr = '0; io_if.wdata = '0;
    step();
    preload = 1'b0;
    step();
    chk("rst_outs", {cpu_if.gnt, io_if.gnt, cpu_if.rvalid, io_if.rvalid, mem_en, mem_we,
                     mem_addr, mem_wdata, cpu_if.rdata, io_if.rdata}, 70'h0);

    cpu_if.req = 1'b1; cpu_if.addr = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold", {mem_en, cpu_if.gnt}, 2'b00);
    end
    reset = 1'b0; cpu_if.req = 1'b0;
    step();
    chk("idle_outs", {cpu_if.gnt, io_if.gnt, cpu_if.rvalid, io_if.rvalid, mem_en, mem_we,
                      cpu_if.rdata, io_if.rdata}, 38'h0);

    cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 16'h0010; cpu_if.wdata = 16'hBEEF;
    step();
    chk("wr_gnt", {cpu_if.gnt, io_if.gnt, mem_en, mem_we, mem_addr, mem_wdata},
                  {4'b1011, 16'h0010, 16'hBEEF});
    cpu_if.req = 1'b0;
    step();
    chk("wr_idle", {cpu_if.gnt, mem_en, mem_we}, 3'b000);

    cpu_if.req = 1'b1; cpu_if.we = 1'b0;
    step();
    chk("rd_gnt", {cpu_if.gnt, io_if.gnt, mem_en, mem_we, cpu_if.rvalid}, 5'b10100);
    cpu_if.req = 1'b0;
    step();
    chk("rd_rvalid", {cpu_if.rvalid, io_if.rvalid, io_if.gnt, cpu_if.rdata, io_if.rdata},
                     {3'b100, 16'hBEEF, 16'h0000});
    step();
    chk("rd_done", {cpu_if.rvalid, mem_en, cpu_if.rdata}, 18'h0);

    io_if.req = 1'b1; io_if.we = 1'b0; io_if.addr = 16'h0020;
    step();
    chk("io_gnt", {cpu_if.gnt, io_if.gnt, mem_en, mem_we, mem_addr}, {4'b0110, 16'h0020});
    io_if.req = 1'b0;
    step();
    chk("io_rvalid", {io_if.rvalid, cpu_if.rvalid, io_if.rdata, cpu_if.rdata},
                     {2'b10, 16'h1234, 16'h0000});
    step();
    chk("io_done", {io_if.rvalid, io_if.rdata}, 17'h0);

    cpu_if.we = 1'b1; cpu_if.addr = 16'h0030; cpu_if.wdata = 16'h1111;
    io_if.we = 1'b1; io_if.addr = 16'h0040; io_if.wdata = 16'h2222;
    cpu_if.req = 1'b1; io_if.req = 1'b1;
    n_acc = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i % 2 == 1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g = (n_acc % 2 == 0) ? 2'b10 : 2'b01;
`else
        exp_g = 2'b10;
`endif
        n_acc++;
      end else begin
        exp_g = 2'b00;
      end
      chk("arb_gnt", {cpu_if.gnt, io_if.gnt}, exp_g);
    end
    cpu_if.req = 1'b0; io_if.req = 1'b0;
    step();
    chk("arb_idle", {cpu_if.gnt, io_if.gnt, mem_en}, 3'b000);

    cpu_if.req = 1'b1; cpu_if.we = 1'b0; cpu_if.addr = 16'h0010;
    step();
    reset = 1'b1;
    #1;
    chk("abort_en", {mem_en, mem_we, cpu_if.gnt}, 3'b000);
    cpu_if.req = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("abort_idle", {cpu_if.rvalid, io_if.rvalid, mem_en, cpu_if.gnt}, 4'b0000);
    step();
    chk("abort_quiet", {cpu_if.rvalid, mem_en, cpu_if.gnt, cpu_if.rdata}, 19'h0);
    cpu_if.req = 1'b1;
    step();
    chk("retry_gnt", {cpu_if.gnt, mem_en, mem_we}, 3'b110);
    cpu_if.req = 1'b0;
    step();
    chk("retry_rd", {cpu_if.rvalid, cpu_if.rdata}, {1'b1, 16'hBEEF});
    step();

    cpu_if.req = 1'b1;
    step();
    chk("late_cgnt", {cpu_if.gnt, io_if.gnt}, 2'b10);
    cpu_if.req = 1'b0;
    step();
    chk("late_crd", {cpu_if.rvalid, cpu_if.rdata, io_if.gnt}, {1'b1, 16'hBEEF, 1'b0});
    io_if.req = 1'b1; io_if.we = 1'b0; io_if.addr = 16'h0020;
    step();
    chk("late_idle", {io_if.gnt, cpu_if.gnt, cpu_if.rvalid, mem_en}, 4'b0000);
    step();
    chk("late_igant", {io_if.gnt, cpu_if.gnt, mem_en}, 3'b101);
    io_if.req = 1'b0;
    step();
    chk("late_ird", {io_if.rvalid, cpu_if.rvalid, io_if.rdata}, {2'b10, 16'h1234});
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
